// File: rtl/clk_divider.sv
// clk_divider: integer clock divider producing a registered divided clock plus a
// one-cycle source-domain strobe on each divided-clock rising edge.
module clk_divider #(
  parameter int unsigned INPUT_CLOCK  = 27000000,
  parameter int unsigned OUTPUT_CLOCK = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_clk,
  output logic o_tick
);
  // 64-bit math so 2*OUTPUT_CLOCK cannot overflow; the guard avoids dividing by zero
  localparam longint unsigned RATIO = (OUTPUT_CLOCK == 0) ? 64'd0 :
                                      64'(INPUT_CLOCK) / (64'(OUTPUT_CLOCK) * 64'd2);
  localparam int unsigned HALF = (RATIO == 64'd0) ? 32'd1 : 32'(RATIO);
  localparam int CW = (HALF <= 2) ? 1 : $clog2(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);
  if (INPUT_CLOCK == 0 || OUTPUT_CLOCK == 0) begin : g_bad_cfg
    $fatal(1, "clk_divider: INPUT_CLOCK and OUTPUT_CLOCK must be nonzero");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d, tick_q, tick_d, wrap;
  always_comb begin
    wrap   = cnt_q == LAST;
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    clk_d  = clk_q ^ wrap;
    tick_d = wrap & ~clk_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end
  assign o_clk  = clk_q;
  assign o_tick = tick_q;
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: four divider configurations checked every cycle against an
// edge-count model, plus literal waveform pins and randomized async resets.
module tb_clk_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] oc, ot;
  longint n = 0;
  int chks = 0, fails = 0;
  int rises = 0;
  localparam int H [4] = '{4, 2, 1, 703};

  always #5 clk = ~clk;

  clk_divider #(.INPUT_CLOCK(8),        .OUTPUT_CLOCK(1))     d0 (.i_clk(clk), .i_rst_n(rst_n), .o_clk(oc[0]), .o_tick(ot[0]));
  clk_divider #(.INPUT_CLOCK(10),       .OUTPUT_CLOCK(2))     d1 (.i_clk(clk), .i_rst_n(rst_n), .o_clk(oc[1]), .o_tick(ot[1]));
  clk_divider #(.INPUT_CLOCK(3),        .OUTPUT_CLOCK(2))     d2 (.i_clk(clk), .i_rst_n(rst_n), .o_clk(oc[2]), .o_tick(ot[2]));
  clk_divider #(.INPUT_CLOCK(27000000), .OUTPUT_CLOCK(19200)) d3 (.i_clk(clk), .i_rst_n(rst_n), .o_clk(oc[3]), .o_tick(ot[3]));

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    chks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // rising edges seen since the last reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else n <= n + 1;

  function automatic bit exp_clk(input longint h, input longint k);
    return ((k / h) % 2) == 1;
  endfunction

  function automatic bit exp_tick(input longint h, input longint k);
    return k > 0 && (k % (2 * h)) == h;
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d_clk", i), oc[i] == exp_clk(H[i], n), longint'(oc[i]), longint'(exp_clk(H[i], n)));
      chk($sformatf("d%0d_tick", i), ot[i] == exp_tick(H[i], n), longint'(ot[i]), longint'(exp_tick(H[i], n)));
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:1] c0, t0, c2, t2;
    c0 = 12'b1000_0111_1000;
    t0 = 12'b1000_0000_1000;
    c2 = 12'b0101_0101_0101;
    t2 = 12'b0101_0101_0101;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("hold_clk", oc == 4'b0, longint'(oc), 0);
      chk("hold_tick", ot == 4'b0, longint'(ot), 0);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("pin_d0_clk_e%0d", k), oc[0] == c0[k], longint'(oc[0]), longint'(c0[k]));
      chk($sformatf("pin_d0_tick_e%0d", k), ot[0] == t0[k], longint'(ot[0]), longint'(t0[k]));
      chk($sformatf("pin_d2_clk_e%0d", k), oc[2] == c2[k], longint'(oc[2]), longint'(c2[k]));
      chk($sformatf("pin_d2_tick_e%0d", k), ot[2] == t2[k], longint'(ot[2]), longint'(t2[k]));
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_mid_high_clk", oc == 4'b0, longint'(oc), 0);
    chk("async_mid_high_tick", ot == 4'b0, longint'(ot), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("restart_d0_clk_e%0d", k), oc[0] == (k == 4), longint'(oc[0]), longint'(k == 4));
    end
    repeat (27000) begin
      @(negedge clk);
      rises += int'(ot[3]);
    end
    chk("d3_rises_1ms", rises >= 18 && rises <= 20, rises, 19);
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 1500)) @(posedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b0;
      #1;
      chk("rand_async_clk", oc == 4'b0, longint'(oc), 0);
      chk("rand_async_tick", ot == 4'b0, longint'(ot), 0);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #2 rst_n = 1'b1;
    end
    repeat (1500) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", chks, fails);
    $finish;
  end
endmodule
